// File: rtl/split_pkg.sv
// Shared types and helpers for the split-veggie motion sequencer.
// Holds the FSM state type, the per-half motion record and the output clamps.
package split_pkg;

    typedef enum logic [1:0] {IDLE, WHOLE, SPLIT, GONE} state_t;

    typedef struct packed {
        logic signed [11:0] x;
        logic signed [11:0] y;
        logic signed [7:0]  vy;
    } half_t;

    function automatic logic off_screen(input half_t h, input int thresh);
        return $signed(h.y) >= thresh;
    endfunction

    function automatic logic [10:0] clamp_x(input logic signed [11:0] x);
        if (x < 0) return 11'd0;
        return x[10:0];
    endfunction

    function automatic logic [9:0] clamp_y(input logic signed [11:0] y);
        if (y < 0) return 10'd0;
        if (y > 12'sd1023) return 10'd1023;
        return y[9:0];
    endfunction

    // Symmetric saturation keeps -128 out so the velocity can always be negated.
    function automatic logic signed [7:0] sat_vy(input logic signed [9:0] v);
        if (v > 10'sd127) return 8'sd127;
        if (v < -10'sd127) return -8'sd127;
        return v[7:0];
    endfunction

endpackage

// File: rtl/half_physics.sv
// Motion register for one sprite half: position plus vertical velocity.
// On upd it moves x by dx, y by the old vy, then adds gravity to vy.
module half_physics
    import split_pkg::*;
#(
    parameter int GRAVITY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  half_t              init,
    input  logic               upd,
    input  logic signed [11:0] dx,
    output half_t              h
);

    logic signed [9:0] vy_sum;
    half_t             nxt;

    always_comb begin
        vy_sum = $signed({{2{h.vy[7]}}, h.vy}) + 10'(GRAVITY);
        nxt.x  = h.x + dx;
        nxt.y  = h.y + {{4{h.vy[7]}}, h.vy};
        nxt.vy = sat_vy(vy_sum);
    end

    always_ff @(posedge clk) begin
        if (rst)
            h <= '0;
        else if (load)
            h <= init;
        else if (upd)
            h <= nxt;
    end

endmodule

// File: rtl/split_animator.sv
// Per-veggie sequencer: launch on a gravity arc, latch the slice, push the
// halves apart and retire the veggie when it falls off screen or times out.
module split_animator
    import split_pkg::*;
#(
    parameter int SCREEN_H         = 768,
    parameter int HEIGHT           = 256,
    parameter int GRAVITY          = 1,
    parameter int SEP_SPEED        = 2,
    parameter int MAX_SPLIT_FRAMES = 120
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        frame_in,
    input  logic        spawn_in,
    input  logic [10:0] spawn_x_in,
    input  logic [9:0]  spawn_y_in,
    input  logic [7:0]  spawn_vy_in,
    input  logic        slice_in,
    input  logic [9:0]  slice_angle_in,
    output logic [10:0] top_x_out,
    output logic [10:0] bot_x_out,
    output logic [9:0]  top_y_out,
    output logic [9:0]  bot_y_out,
    output logic        split_out,
    output logic [9:0]  angle_out,
    output logic        busy_out,
    output logic        veggie_gone_out,
    output logic        missed_out
);

    localparam int                 OFF_Y = SCREEN_H + HEIGHT / 2;
    localparam int                 CW    = $clog2(MAX_SPLIT_FRAMES + 1);
    localparam logic signed [11:0] SEP   = 12'(SEP_SPEED);

    state_t             state, state_n;
    half_t              top_h, bot_h, init_h;
    logic [CW-1:0]      split_cnt;
    logic               load, upd, take_slice;
    logic signed [11:0] dx_top, dx_bot;

    assign init_h = '{x: {1'b0, spawn_x_in}, y: {2'b00, spawn_y_in}, vy: spawn_vy_in};

    always_comb begin
        state_n    = state;
        load       = 1'b0;
        upd        = 1'b0;
        take_slice = 1'b0;
        dx_top     = '0;
        dx_bot     = '0;
        case (state)
            IDLE: begin
                if (spawn_in) begin
                    load    = 1'b1;
                    state_n = WHOLE;
                end
            end
            WHOLE: begin
                // A slice arriving with a frame still moves the veggie as one piece.
                upd = frame_in;
                if (slice_in) begin
                    take_slice = 1'b1;
                    state_n    = SPLIT;
                end else if (!top_h.vy[7] && top_h.vy != '0 && off_screen(top_h, OFF_Y)) begin
                    state_n = GONE;
                end
            end
            SPLIT: begin
                upd    = frame_in;
                dx_top = -SEP;
                dx_bot = SEP;
                if (split_cnt >= CW'(MAX_SPLIT_FRAMES) ||
                    (off_screen(top_h, OFF_Y) && off_screen(bot_h, OFF_Y)))
                    state_n = GONE;
            end
            GONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state           <= IDLE;
            split_cnt       <= '0;
            angle_out       <= '0;
            split_out       <= 1'b0;
            busy_out        <= 1'b0;
            veggie_gone_out <= 1'b0;
            missed_out      <= 1'b0;
        end else begin
            state <= state_n;
            if (take_slice) begin
                split_cnt <= '0;
                angle_out <= slice_angle_in;
            end else if (upd && state == SPLIT && split_cnt < CW'(MAX_SPLIT_FRAMES)) begin
                split_cnt <= split_cnt + 1'b1;
            end
            split_out       <= (state_n == SPLIT);
            busy_out        <= (state_n == WHOLE) || (state_n == SPLIT);
            veggie_gone_out <= (state_n == GONE);
            missed_out      <= (state_n == GONE) && (state == WHOLE);
        end
    end

    half_physics #(.GRAVITY(GRAVITY)) u_top (
        .clk  (pixel_clk_in),
        .rst  (rst_in),
        .load (load),
        .init (init_h),
        .upd  (upd),
        .dx   (dx_top),
        .h    (top_h)
    );

    half_physics #(.GRAVITY(GRAVITY)) u_bot (
        .clk  (pixel_clk_in),
        .rst  (rst_in),
        .load (load),
        .init (init_h),
        .upd  (upd),
        .dx   (dx_bot),
        .h    (bot_h)
    );

    assign top_x_out = clamp_x(top_h.x);
    assign bot_x_out = clamp_x(bot_h.x);
    assign top_y_out = clamp_y(top_h.y);
    assign bot_y_out = clamp_y(bot_h.y);

endmodule

// File: doc/split_animator.md
Name: split_animator

Overview:
- Per-veggie motion and slice sequencer; drives position, split and angle inputs of one split_sprite pair (top half and bottom half instances).
- Launches a whole veggie on a gravity arc and captures a slice event (angle latched).
- Animates the two halves apart and retires the veggie when it leaves the screen or a timeout expires.
- All updates are frame-paced; outputs are registered and held stable between frame ticks.

Parameters:
- SCREEN_H, 768, visible lines; off-screen threshold = SCREEN_H + HEIGHT/2
- HEIGHT, 256, sprite height in pixels (must match split_sprite HEIGHT)
- GRAVITY, 1, added to vertical velocity each frame (px/frame²)
- SEP_SPEED, 2, horizontal separation speed of each half after slice (px/frame)
- MAX_SPLIT_FRAMES, 120, frames in SPLIT before forced retire

Ports:
- pixel_clk_in  in  1  pixel clock
- rst_in  in  1  synchronous active-high reset
- frame_in  in  1  one-cycle pulse per frame (first blanking cycle)
- spawn_in  in  1  one-cycle launch request
- spawn_x_in  in  11  launch centre x
- spawn_y_in  in  10  launch centre y
- spawn_vy_in  in  8  signed launch vertical velocity (negative = up)
- slice_in  in  1  one-cycle slice event from blade/hit logic
- slice_angle_in  in  10  cut angle, degrees 0..359
- top_x_out, bot_x_out  out  11  half-sprite centre x
- top_y_out, bot_y_out  out  10  half-sprite centre y
- split_out  out  1  1 = halves separated (split_sprite cut mode)
- angle_out  out  10  latched cut angle
- busy_out  out  1  veggie active (WHOLE or SPLIT)
- veggie_gone_out  out  1  one-cycle pulse on retire
- missed_out  out  1  one-cycle pulse when retired unsliced

Behaviour:
- Reset values: all positions 0, split_out 0, angle_out 0, busy_out 0, both pulse outputs 0, state IDLE.
- Reset mid-operation aborts immediately to IDLE. No gone or missed pulse is issued.
- Internal state per half:
  - x: signed 12 bit
  - y: signed 12 bit
  - vy: signed 8 bit, saturating at ±127
- Output clamping:
  - negative x or y is output as 0
  - x > 2047 is output as 2047; y > 1023 is output as 1023
- IDLE:
  - spawn_in loads both halves with x = spawn_x_in, y = spawn_y_in, vy = spawn_vy_in.
  - Next state is WHOLE; busy_out = 1 from the next cycle.
- WHOLE:
  - On frame_in, both halves update identically: y <= y + vy, then vy <= vy + GRAVITY. The new y uses the old vy.
  - slice_in: latch angle_out <= slice_angle_in, set split_out = 1, clear the split frame counter, go to SPLIT.
  - Retire when vy > 0 and y >= SCREEN_H + HEIGHT/2: go to GONE with missed flag set.
- SPLIT, on each frame_in:
  - top x <= x − SEP_SPEED; bottom x <= x + SEP_SPEED
  - both halves apply the vertical update above
  - counter increments
- Leaving SPLIT:
  - Go to GONE when both halves are past the off-screen threshold, or when the counter reaches MAX_SPLIT_FRAMES.
  - Missed flag is clear on this path.
- GONE: lasts exactly one cycle.
  - veggie_gone_out = 1; missed_out = missed flag.
  - Clears split_out and busy_out; returns to IDLE.
- Latency: outputs reflect a frame update on the cycle after frame_in.
- Simultaneous events:
  - slice_in with frame_in in WHOLE: that frame's update uses the WHOLE rule (no separation), and the state becomes SPLIT.
  - spawn_in while busy: ignored.
  - spawn_in during GONE: ignored; it must be re-requested in IDLE.
  - slice_in outside WHOLE: ignored; the angle is not re-latched.
- Validity: angle_out is valid only while split_out = 1.

Decomposition:
- Package split_pkg holds:
  - typedef state_t {IDLE, WHOLE, SPLIT, GONE}
  - typedef half_t struct {x, y, vy}
  - function off_screen(half_t)
  - function clamp_x / clamp_y
- One natural sub-module: half_physics.
  - Registers one half_t and applies the per-frame update given dx and an update enable.
  - Instantiated twice (top and bottom).

Test Plan:
- Launch ascent: spawn x=512, y=700, vy=−20, then 2 frames → top_y/bot_y = 680 then 661; vy = −18; split_out = 0; busy_out = 1.
- Unsliced retire: spawn y=700, vy=−5, run frames until y ≥ 896 → exactly one cycle with veggie_gone_out = 1 and missed_out = 1; then busy_out = 0.
- Slice and separate: in WHOLE, slice_in with angle=45 at x=512, then 3 frames → angle_out = 45; top_x = 506; bot_x = 518; split_out = 1.
- Timeout: slice at the peak, then 120 frames with y held on screen (GRAVITY=0 build) → gone pulse on frame 120 with missed_out = 0.
- Simultaneous events: slice_in and frame_in on the same cycle → x unchanged that frame and split_out = 1; spawn_in during SPLIT is ignored (positions unaffected).
- Reset mid-SPLIT: rst_in for 1 cycle → all outputs 0, no gone pulse; a following spawn works normally.
